// File: rtl/autocorr_pkg.sv
// autocorr_pkg: shared defaults and FSM state encoding for the autocorrelation block
package autocorr_pkg;
  localparam int N_DEF = 320;
  localparam int ORDER_DEF = 10;
  localparam int XW_DEF = 16;
  localparam int RW_DEF = 32;
  localparam int AW_DEF = 9;
  localparam int ACCW_DEF = 48;
  localparam int SHIFT_DEF = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_A,
    S_ADDR_B,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;
endpackage

// File: rtl/autocorr_mac.sv
// autocorr_mac: signed multiply-accumulate with shifted, saturated readout
module autocorr_mac import autocorr_pkg::*; #(
  parameter int XW = XW_DEF,
  parameter int RW = RW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [XW-1:0] a,
  input  logic [XW-1:0] b,
  output logic [RW-1:0] sat_out
);
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-RW+1){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-RW+1){1'b1}}, {(RW-1){1'b0}}};
  logic signed [ACCW-1:0] acc_q, acc_d, prod_x, shifted;
  logic signed [2*XW-1:0] prod;
  // product sign-extended into the accumulator; readout clamps to the RW range
  always_comb begin
    prod = $signed(a) * $signed(b);
    prod_x = {{(ACCW-2*XW){prod[2*XW-1]}}, prod};
    acc_d = clear ? '0 : enable ? acc_q + prod_x : acc_q;
    shifted = acc_q >>> SHIFT;
    sat_out = shifted > MAXV ? MAXV[RW-1:0] : shifted < MINV ? MINV[RW-1:0] : shifted[RW-1:0];
  end
  // accumulator register
  always_ff @(posedge clk or negedge rst)
    if (!rst) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/autocorrelate_rn.sv
// autocorrelate_rn: LPC autocorrelation R[k] over one frame, written to the Rn RAM
module autocorrelate_rn import autocorr_pkg::*; #(
  parameter int N = N_DEF,
  parameter int ORDER = ORDER_DEF,
  parameter int XW = XW_DEF,
  parameter int RW = RW_DEF,
  parameter int AW = AW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] x_addr,
  input  logic [XW-1:0] x_data,
  output logic [AW-1:0] rn_addr,
  output logic [RW-1:0] rn_wdata,
  output logic          rn_wren
);
  localparam logic [AW-1:0] N_LAST = AW'(N - 1);
  localparam logic [AW-1:0] K_LAST = AW'(ORDER);
  state_t state_q, state_d;
  logic [AW-1:0] k_q, k_d, n_q, n_d, x_addr_q, x_addr_d;
  logic [XW-1:0] a_q, a_d;
  logic clr, en;
  autocorr_mac #(.XW(XW), .RW(RW), .ACCW(ACCW), .SHIFT(SHIFT)) u_mac (
    .clk(clk),
    .rst(rst),
    .clear(clr),
    .enable(en),
    .a(a_q),
    .b(x_data),
    .sat_out(rn_wdata)
  );
  // x_addr is registered, so it is loaded on the transition into the state that presents it
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    n_d = n_q;
    a_d = a_q;
    x_addr_d = x_addr_q;
    clr = 1'b0;
    en = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ADDR_A;
        k_d = '0;
        n_d = '0;
        x_addr_d = '0;
        clr = 1'b1;
      end
      S_ADDR_A: begin
        state_d = S_ADDR_B;
        x_addr_d = n_q;
      end
      S_ADDR_B: begin
        state_d = S_MAC;
        a_d = x_data;
      end
      S_MAC: begin
        en = 1'b1;
        if (n_q == N_LAST) state_d = S_WRITE;
        else begin
          state_d = S_ADDR_A;
          n_d = n_q + 1'b1;
          x_addr_d = n_q + 1'b1 - k_q;
        end
      end
      S_WRITE: if (k_q == K_LAST) state_d = S_DONE;
      else begin
        state_d = S_ADDR_A;
        k_d = k_q + 1'b1;
        n_d = k_q + 1'b1;
        x_addr_d = '0;
        clr = 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // state, counters, first operand and read address
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      k_q <= '0;
      n_q <= '0;
      a_q <= '0;
      x_addr_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      n_q <= n_d;
      a_q <= a_d;
      x_addr_q <= x_addr_d;
    end
  assign x_addr = x_addr_q;
  assign rn_addr = k_q;
  assign rn_wren = state_q == S_WRITE;
  assign done = state_q == S_DONE;
  assign busy = state_q inside {S_ADDR_A, S_ADDR_B, S_MAC, S_WRITE};
endmodule

// File: tb/tb_autocorrelate_rn.sv
// tb_autocorrelate_rn: default and SHIFT=0 instances checked against a sum-of-products model
module tb_autocorrelate_rn;
  localparam int N = 320;
  localparam int ORDER = 10;
  localparam longint TD = 3 * 3465 + 11;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [8:0] xa0, xa1, ra0, ra1;
  logic [15:0] xd0, xd1;
  logic [31:0] rd0, rd1;
  logic we0, we1, busy0, busy1, done0, done1;
  logic [15:0] xmem [512];
  logic [31:0] rn0 [16], rn1 [16];
  longint exp0 [ORDER+1], exp1 [ORDER+1];
  int checks = 0, failures = 0, w0 = 0, w1 = 0;
  longint cyc = 0, e0 = 0;
  bit run = 1'b0;

  autocorrelate_rn dut0 (.clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .x_addr(xa0), .x_data(xd0), .rn_addr(ra0), .rn_wdata(rd0), .rn_wren(we0));
  autocorrelate_rn #(.SHIFT(0)) dut1 (.clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .x_addr(xa1), .x_data(xd1), .rn_addr(ra1), .rn_wdata(rd1), .rn_wren(we1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    xd0 <= xmem[xa0];
    xd1 <= xmem[xa1];
    if (we0) rn0[ra0[3:0]] <= rd0;
    if (we1) rn1[ra1[3:0]] <= rd1;
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic longint sat(input longint v);
    return v > 64'sd2147483647 ? 64'sd2147483647 : v < -64'sd2147483648 ? -64'sd2147483648 : v;
  endfunction

  task automatic model();
    for (int k = 0; k <= ORDER; k++) begin
      longint s = 0;
      for (int n = k; n < N; n++) s += longint'($signed(xmem[n])) * longint'($signed(xmem[n-k]));
      exp0[k] = sat(s >>> 8);
      exp1[k] = sat(s);
    end
  endtask

  always @(negedge clk) if (run) begin
    chk("busy", {busy0, busy1}, (cyc >= e0 && cyc < e0 + TD) ? 2'b11 : 2'b00);
    chk("done", {done0, done1}, cyc == e0 + TD ? 2'b11 : 2'b00);
    if (we0) begin
      if (w0 > ORDER) chk("extra_write0", w0 + 1, ORDER + 1);
      else begin
        chk("rn_addr0", ra0, w0);
        chk("rn_wdata0", $signed(rd0), exp0[w0]);
      end
      w0++;
    end
    if (we1) begin
      if (w1 > ORDER) chk("extra_write1", w1 + 1, ORDER + 1);
      else begin
        chk("rn_addr1", ra1, w1);
        chk("rn_wdata1", $signed(rd1), exp1[w1]);
      end
      w1++;
    end
    if (cyc == e0 + TD) chk("write_count", w0 * 100 + w1, (ORDER + 1) * 101);
  end

  task automatic fill(input int mode);
    for (int n = 0; n < 512; n++)
      case (mode)
        1: xmem[n] = 16'd1;
        2: xmem[n] = n == 0 ? 16'd100 : 16'd0;
        3: xmem[n] = n[0] ? 16'hFFFF : 16'd1;
        4: xmem[n] = 16'h8000;
        5: xmem[n] = 16'($urandom);
        6: xmem[n] = 16'($signed($urandom_range(0, 4095)) - 2048);
        default: xmem[n] = 16'd0;
      endcase
  endtask

  task automatic launch(input bit stray);
    model();
    w0 = 0;
    w1 = 0;
    @(negedge clk);
    start = 1'b1;
    e0 = cyc + 1;
    run = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (stray) begin
      repeat (49) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic finish_frame();
    for (int i = 0; i < TD + 100 && !done0; i++) @(negedge clk);
    chk("done_seen", done0, 1'b1);
    repeat (2) @(negedge clk);
    run = 1'b0;
  endtask

  initial begin
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst_outputs0", {xa0, ra0, rd0, we0, busy0, done0}, 0);
    chk("rst_outputs1", {xa1, ra1, rd1, we1, busy1, done1}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    launch(1'b1);
    finish_frame();
    chk("zero_r0", $signed(rn0[0]), 0);
    chk("zero_r10", $signed(rn1[10]), 0);
    fill(1);
    launch(1'b0);
    chk("model_ones", exp1[10], 310);
    finish_frame();
    chk("ones_r0", $signed(rn1[0]), 320);
    chk("ones_r10", $signed(rn1[10]), 310);
    chk("ones_shift8_r0", $signed(rn0[0]), 1);
    fill(2);
    launch(1'b0);
    finish_frame();
    chk("imp_r0", $signed(rn1[0]), 10000);
    chk("imp_r1", $signed(rn1[1]), 0);
    fill(3);
    launch(1'b0);
    chk("model_alt", exp1[1], -319);
    finish_frame();
    chk("alt_r1", $signed(rn1[1]), -319);
    chk("alt_r2", $signed(rn1[2]), 318);
    fill(4);
    launch(1'b0);
    finish_frame();
    chk("min_sat_r0", rn1[0], 32'h7FFFFFFF);
    chk("min_sat_r10", rn1[10], 32'h7FFFFFFF);
    chk("min_sh8_r0", rn0[0], 32'h50000000);
    chk("min_sh8_r10", rn0[10], 32'h4D800000);
    fill(5);
    launch(1'b0);
    while (cyc < e0 + 4999) @(negedge clk);
    run = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_outputs", {busy0, busy1, done0, done1, we0, we1}, 0);
    chk("partial_writes", w0 * 100 + w1, 505);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b1;
      chk("post_rst_idle", {busy0, busy1, done0, done1, we0, we1}, 0);
    end
    launch(1'b0);
    finish_frame();
    fill(6);
    launch(1'b0);
    finish_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/autocorrelate_rn.md
# autocorrelate_rn

Computes the LPC autocorrelation sequence R[k] = Σ_{n=k}^{N-1} x[n]·x[n−k] for k = 0..ORDER over one windowed speech frame. Samples come from the windowed-speech sample RAM. Results go into the Rn RAM (RAM_autocorrelate_Rn) at address k. The block sits between the windowing stage and the Levinson-Durbin stage in the Codec2 2400 encoder, and is started once per frame by the encoder top-level FSM.

## Interface
Parameters:
- N, 320, frame length in samples
- ORDER, 10, highest lag computed; ORDER+1 words are written
- XW, 16, sample width, signed
- RW, 32, Rn word width, signed
- AW, 9, address width of both RAMs
- ACCW, 48, accumulator width, signed
- SHIFT, 8, right-shift applied to the accumulator before saturation

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  frame start request, sampled in IDLE only
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when all ORDER+1 words are written
- x_addr  out  AW  sample RAM read address
- x_data  in  XW  sample RAM read data; valid one cycle after x_addr
- rn_addr  out  AW  Rn RAM address, equal to k
- rn_wdata  out  RW  Rn RAM write data
- rn_wren  out  1  Rn RAM write enable, one cycle per lag

## Operation
- States: IDLE, ADDR_A, ADDR_B, MAC, WRITE, DONE.
- IDLE: waits for start. With start=1, sets k=0, n=0, acc=0, busy=1, then → ADDR_A.
- ADDR_A: drives x_addr=n−k, then → ADDR_B.
- ADDR_B: latches a ← x_data, drives x_addr=n, then → MAC.
- MAC: acc ← acc + a·x_data (signed 2·XW product, sign-extended to ACCW).
  - If n == N−1 → WRITE.
  - Otherwise n ← n+1 and → ADDR_A.
- WRITE: drives rn_addr=k and rn_wdata=sat_RW(acc >>> SHIFT), with rn_wren=1 for this cycle.
  - If k == ORDER → DONE.
  - Otherwise k ← k+1, n ← k+1, acc ← 0, and → ADDR_A.
- DONE: done=1, busy=0, then → IDLE.
- Arithmetic shift is sign-preserving. Saturation clamps to [−2^(RW−1), 2^(RW−1)−1].
  - With the default parameters saturation is unreachable.
  - With SHIFT=0 it is reachable and must clamp correctly.
- start while busy is ignored, and so is start in DONE. A request is never queued.
- Addresses n−k are always ≥ 0 because n starts at k for each lag.

## Timing
- Reset values: x_addr=0, rn_addr=0, rn_wdata=0, rn_wren=0, busy=0, done=0. FSM=IDLE, acc=0, k=0, n=0.
- Reset mid-frame: returns to IDLE immediately. No further writes occur; words already written stay in the RAM. No done pulse is produced.
- Per product: 3 cycles. Per lag: one WRITE cycle.
- Total products: Σ_{k=0}^{ORDER}(N−k) = 3465 for the defaults.
- Clock edge E0 samples start=1. The FSM is in DONE, with done=1, in the cycle following edge E0+3·3465+11 = E0+10406.
- rn_wren is high for exactly ORDER+1 cycles per frame, with rn_addr = 0,1,…,ORDER in order.
- x_addr is only meaningful in ADDR_A and ADDR_B. Its value elsewhere is don't-care, but it holds its last value.

## Structure
- Shared package autocorr_pkg: N, ORDER, XW, RW, AW, ACCW, SHIFT defaults, plus the state encoding constants.
- Sub-module autocorr_mac: signed multiply-accumulate.
  - Inputs: clear, enable, a, b.
  - Output: sat_out, which is sat_RW(acc >>> SHIFT).
  - Holds the ACCW accumulator.
- Top level contains the FSM, the n and k counters, and the address generation.
- The bench instantiates the existing Rn RAM and a behavioural sample RAM with 1-cycle read latency.

## Test plan
- All-zero frame, defaults → R[0..10] = 0; 11 writes; done at E0+10406.
- SHIFT=0, x[n]=1 for all n → R[k] = 320−k (R[0]=320, R[10]=310).
- SHIFT=0, impulse x[0]=100, others 0 → R[0]=10000, R[1..10]=0.
- SHIFT=0, x[n] = (−1)^n → R[k] = (−1)^k·(320−k) (R[1]=−319, R[2]=318).
- SHIFT=0, x[n] = −32768 for all n → R[k] saturates to 0x7FFFFFFF for every k.
- Defaults, x[n] = −32768: R[0] = 320·2^30 >>> 8 = 0x50000000.
- Control scenario:
  - Pulse start again at E0+50 → ignored; exactly 11 writes occur.
  - In a second run, assert rst low at E0+5000 → no done pulse, busy=0, rn_wren=0.
  - Release rst and start again → full correct frame.
